// File: rtl/xoodoo_sca_pkg.sv
// Shared constants, FSM encoding and lane/plane shift helpers for the masked Xoodoo engine.
package xoodoo_sca_pkg;

  localparam int STATE_W    = 384;
  localparam int LANE_W     = 32;
  localparam int PLANE_W    = 128;
  localparam int MAX_ROUNDS = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL  = 2'd2,
    ST_CMP  = 2'd3
  } fsm_t;

  function automatic logic [LANE_W-1:0] round_const(input logic [3:0] idx);
    logic [LANE_W-1:0] c;
    case (idx)
      4'd0:    c = 32'h0000_0058;
      4'd1:    c = 32'h0000_0038;
      4'd2:    c = 32'h0000_03C0;
      4'd3:    c = 32'h0000_00D0;
      4'd4:    c = 32'h0000_0120;
      4'd5:    c = 32'h0000_0014;
      4'd6:    c = 32'h0000_0060;
      4'd7:    c = 32'h0000_002C;
      4'd8:    c = 32'h0000_0380;
      4'd9:    c = 32'h0000_00F0;
      4'd10:   c = 32'h0000_01A0;
      4'd11:   c = 32'h0000_0012;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [LANE_W-1:0] lane_rotl(input logic [LANE_W-1:0] l, input int v);
    logic [2*LANE_W-1:0] d;
    d = {l, l} << v;
    return d[2*LANE_W-1:LANE_W];
  endfunction

  // Lane x lands in lane (x+t) mod 4, each lane rotated left by v.
  function automatic logic [PLANE_W-1:0] plane_shift(input logic [PLANE_W-1:0] p,
                                                     input int t, input int v);
    logic [PLANE_W-1:0] o;
    o = '0;
    for (int x = 0; x < 4; x++) begin
      o[LANE_W*((x+t)%4) +: LANE_W] = lane_rotl(p[LANE_W*x +: LANE_W], v);
    end
    return o;
  endfunction

endpackage

// File: rtl/xoodoo_dom_and_sca.sv
// One-bit two-share DOM AND: registers inner and cross terms (cross terms share one random bit),
// and presents the compressed output shares combinationally from those registers.
module xoodoo_dom_and_sca (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic r,
  output logic c0,
  output logic c1
);

  logic inner0, inner1, cross01, cross10;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inner0  <= 1'b0;
      inner1  <= 1'b0;
      cross01 <= 1'b0;
      cross10 <= 1'b0;
    end else if (en) begin
      inner0  <= a0 & b0;
      inner1  <= a1 & b1;
      cross01 <= (a0 & b1) ^ r;
      cross10 <= (a1 & b0) ^ r;
    end
  end

  assign c0 = inner0 ^ cross01;
  assign c1 = inner1 ^ cross10;

endmodule

// File: rtl/xoodoo_perm_sca.sv
// First-order DOM-masked Xoodoo permutation, one round per MUL/CMP cycle pair.
// Define XOODOO_SCA_REFRESH_EN to add a LOAD state that re-randomises the input share split.
module xoodoo_perm_sca
  import xoodoo_sca_pkg::*;
#(
  parameter int NUM_ROUNDS = 12,
  parameter int RS_W       = 384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [STATE_W-1:0] din0,
  input  logic [STATE_W-1:0] din1,
  input  logic [RS_W-1:0]    rs,
  input  logic               rs_valid,
  output logic               rs_ready,
  output logic [STATE_W-1:0] dout0,
  output logic [STATE_W-1:0] dout1,
  output logic               done
);

  fsm_t state_q, state_d;

  logic [3:0]         cnt_q;
  logic [STATE_W-1:0] s0_q, s1_q, l0_q, l1_q;
  logic               done_q;
  logic               load_st, mul_en, cmp_st, last;
`ifdef XOODOO_SCA_REFRESH_EN
  logic               refresh_st;
`endif

  logic [LANE_W-1:0]  rc;
  logic [STATE_W-1:0] lin0, lin1;
  logic [STATE_W-1:0] a0_v, a1_v, b0_v, b1_v;
  logic [STATE_W-1:0] c0_v, c1_v;

  // theta followed by rho_west; linear, so applied to each share independently
  function automatic logic [STATE_W-1:0] lin_layer(input logic [STATE_W-1:0] a);
    logic [PLANE_W-1:0] p, e;
    logic [STATE_W-1:0] o;
    p = a[0 +: PLANE_W] ^ a[PLANE_W +: PLANE_W] ^ a[2*PLANE_W +: PLANE_W];
    e = plane_shift(p, 1, 5) ^ plane_shift(p, 1, 14);
    o[0 +: PLANE_W]         = a[0 +: PLANE_W] ^ e;
    o[PLANE_W +: PLANE_W]   = plane_shift(a[PLANE_W +: PLANE_W] ^ e, 1, 0);
    o[2*PLANE_W +: PLANE_W] = plane_shift(a[2*PLANE_W +: PLANE_W] ^ e, 0, 11);
    return o;
  endfunction

  function automatic logic [STATE_W-1:0] rho_east(input logic [STATE_W-1:0] a);
    logic [STATE_W-1:0] o;
    o[0 +: PLANE_W]         = a[0 +: PLANE_W];
    o[PLANE_W +: PLANE_W]   = plane_shift(a[PLANE_W +: PLANE_W], 0, 1);
    o[2*PLANE_W +: PLANE_W] = plane_shift(a[2*PLANE_W +: PLANE_W], 2, 8);
    return o;
  endfunction

  assign last  = (cnt_q == 4'(NUM_ROUNDS - 1));
  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign dout0 = s0_q;
  assign dout1 = s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rs_ready = 1'b0;
    load_st  = 1'b0;
    mul_en   = 1'b0;
    cmp_st   = 1'b0;
`ifdef XOODOO_SCA_REFRESH_EN
    refresh_st = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_st = 1'b1;
`ifdef XOODOO_SCA_REFRESH_EN
          state_d = ST_LOAD;
`else
          state_d = ST_MUL;
`endif
        end
      end
      ST_LOAD: begin
`ifdef XOODOO_SCA_REFRESH_EN
        if (rs_valid) begin
          rs_ready   = 1'b1;
          refresh_st = 1'b1;
          state_d    = ST_MUL;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_MUL: begin
        rs_ready = rs_valid;
        if (rs_valid) begin
          mul_en  = 1'b1;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        cmp_st  = 1'b1;
        state_d = last ? ST_IDLE : ST_MUL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round constants come from the tail of the table, so short builds use the final rounds.
  assign rc   = round_const(4'(MAX_ROUNDS - NUM_ROUNDS) + cnt_q);
  assign lin0 = lin_layer(s0_q) ^ {{(STATE_W-LANE_W){1'b0}}, rc};
  assign lin1 = lin_layer(s1_q);

  always_comb begin
    a0_v = '0;
    a1_v = '0;
    b0_v = '0;
    b1_v = '0;
    for (int y = 0; y < 3; y++) begin
      a0_v[PLANE_W*y +: PLANE_W] = ~lin0[PLANE_W*((y+1)%3) +: PLANE_W];
      a1_v[PLANE_W*y +: PLANE_W] =  lin1[PLANE_W*((y+1)%3) +: PLANE_W];
      b0_v[PLANE_W*y +: PLANE_W] =  lin0[PLANE_W*((y+2)%3) +: PLANE_W];
      b1_v[PLANE_W*y +: PLANE_W] =  lin1[PLANE_W*((y+2)%3) +: PLANE_W];
    end
  end

  genvar g;
  for (g = 0; g < STATE_W; g++) begin : g_dom
    xoodoo_dom_and_sca u_and (
      .clk (clk),
      .rst (rst),
      .en  (mul_en),
      .a0  (a0_v[g]),
      .a1  (a1_v[g]),
      .b0  (b0_v[g]),
      .b1  (b1_v[g]),
      .r   (rs[g]),
      .c0  (c0_v[g]),
      .c1  (c1_v[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q   <= '0;
      s1_q   <= '0;
      l0_q   <= '0;
      l1_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= cmp_st & last;
      if (load_st) begin
        s0_q  <= din0;
        s1_q  <= din1;
        cnt_q <= '0;
      end
`ifdef XOODOO_SCA_REFRESH_EN
      if (refresh_st) begin
        s0_q <= s0_q ^ rs;
        s1_q <= s1_q ^ rs;
      end
`endif
      if (mul_en) begin
        l0_q <= lin0;
        l1_q <= lin1;
      end
      if (cmp_st) begin
        s0_q <= rho_east(l0_q ^ c0_v);
        s1_q <= rho_east(l1_q ^ c1_v);
        if (!last) cnt_q <= cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_xoodoo_perm_sca.sv
// Randomised bench for xoodoo_perm_sca against an unmasked lane-array Xoodoo model.
module tb_xoodoo_perm_sca;

  localparam int NR = 12;
`ifdef XOODOO_SCA_REFRESH_EN
  localparam int REF = 1;
`else
  localparam int REF = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, start6, rs_valid;
  logic         ready, rs_ready, done, ready6, rs_ready6, done6;
  logic [383:0] din0, din1, rs, dout0, dout1, dout0_6, dout1_6;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  xoodoo_perm_sca dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .din0(din0), .din1(din1), .rs(rs), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .dout0(dout0), .dout1(dout1), .done(done)
  );

  xoodoo_perm_sca #(.NUM_ROUNDS(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .ready(ready6),
    .din0(din0), .din1(din1), .rs(rs), .rs_valid(1'b1), .rs_ready(rs_ready6),
    .dout0(dout0_6), .dout1(dout1_6), .done(done6)
  );

  task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
    return (v << n) | (v >> ((32 - n) % 32));
  endfunction

  // Plain Xoodoo on a[plane][lane], last nr rounds of the 12-round schedule.
  function automatic logic [383:0] xoodoo_ref(input logic [383:0] s, input int nr);
    logic [31:0] a[3][4];
    logic [31:0] t[4];
    logic [31:0] p[4];
    logic [31:0] e[4];
    logic [31:0] b[3][4];
    logic [31:0] rct[12];
    logic [383:0] o;
    rct = '{32'h58, 32'h38, 32'h3C0, 32'hD0, 32'h120, 32'h14,
            32'h60, 32'h2C, 32'h380, 32'hF0, 32'h1A0, 32'h12};
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = s[128*y + 32*x +: 32];
    for (int r = 12 - nr; r < 12; r++) begin
      for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int x = 0; x < 4; x++) e[x] = rotl32(p[(x+3)%4], 5) ^ rotl32(p[(x+3)%4], 14);
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] ^= e[x];
      for (int x = 0; x < 4; x++) t[x] = a[1][(x+3)%4];
      for (int x = 0; x < 4; x++) begin
        a[1][x] = t[x];
        a[2][x] = rotl32(a[2][x], 11);
      end
      a[0][0] ^= rct[r];
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) b[y][x] = ~a[(y+1)%3][x] & a[(y+2)%3][x];
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] ^= b[y][x];
      for (int x = 0; x < 4; x++) t[x] = rotl32(a[2][(x+2)%4], 8);
      for (int x = 0; x < 4; x++) begin
        a[1][x] = rotl32(a[1][x], 1);
        a[2][x] = t[x];
      end
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) o[128*y + 32*x +: 32] = a[y][x];
    return o;
  endfunction

  // Called #1 after an edge; returns #1 after the edge that raised done (or after the budget).
  task automatic run_op(input logic [383:0] m0, input logic [383:0] m1,
                        input int stall, input bit bogus, output int lat);
    int k;
    check_eq("ready_at_start", ready, 1);
    din0 = m0; din1 = m1; start = 1'b1; rs_valid = 1'b1; rs = rand384();
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      rs = rand384();
      rs_valid = !(stall > 0 && k >= 6 + REF && k < 6 + REF + stall);
      if (bogus && (k == 3 || k == 10)) begin
        start = 1'b1; din0 = rand384(); din1 = rand384();
      end else begin
        start = 1'b0;
      end
      #1;
      if (k == 0) check_eq("done_low_after_accept", done, 0);
      if (k == 0) check_eq("rs_ready_first", rs_ready, 1);
      if (k == 1 + REF) check_eq("rs_ready_in_cmp", rs_ready, 0);
      if (!rs_valid) check_eq("rs_ready_stalled", rs_ready, 0);
      if (bogus && (k == 3 || k == 10)) check_eq("ready_busy", ready, 0);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    rs_valid = 1'b1;
    check_eq("done_seen", done, 1);
    lat = k;
  endtask

  initial begin
    logic [383:0] m, sv, d0a, exp0;
    int lat;

    rst = 1'b1; start = 1'b0; start6 = 1'b0; rs_valid = 1'b0;
    din0 = '0; din1 = '0; rs = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset_ready", ready, 1);
    check_eq("reset_done", done, 0);
    check_eq("reset_dout0", dout0, '0);
    check_eq("reset_dout1", dout1, '0);
    @(posedge clk); #1;

    // Equal shares: unmasked state is zero.
    exp0 = xoodoo_ref('0, NR);
    m = rand384();
    run_op(m, m, 0, 1'b0, lat);
    check_eq("lat_zero_a", lat, 2*NR + REF);
    check_eq("xor_zero_a", dout0 ^ dout1, exp0);
    d0a = dout0;
    m = rand384();
    run_op(m, m, 0, 1'b0, lat);
    check_eq("lat_zero_b", lat, 2*NR + REF);
    check_eq("xor_zero_b", dout0 ^ dout1, exp0);
    check_eq("shares_differ", dout0 != d0a, 1);

    // Random masked states, stalled in the fourth MUL.
    for (int i = 0; i < 3; i++) begin
      sv = rand384(); m = rand384();
      run_op(sv ^ m, m, 3, 1'b0, lat);
      check_eq("lat_stall", lat, 2*NR + REF + 3);
      check_eq("xor_stall", dout0 ^ dout1, xoodoo_ref(sv, NR));
    end

    // Ignored starts mid-run, then a back-to-back start in the done cycle.
    sv = rand384(); m = rand384();
    run_op(sv ^ m, m, 0, 1'b1, lat);
    check_eq("lat_bogus", lat, 2*NR + REF);
    check_eq("xor_bogus", dout0 ^ dout1, xoodoo_ref(sv, NR));
    check_eq("ready_with_done", ready, 1);
    sv = rand384(); m = rand384();
    run_op(sv ^ m, m, 0, 1'b0, lat);
    check_eq("lat_b2b", lat, 2*NR + REF);
    check_eq("xor_b2b", dout0 ^ dout1, xoodoo_ref(sv, NR));
    repeat (3) begin
      rs = rand384(); rs_valid = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    rs_valid = 1'b1;
    check_eq("done_pulse_low", done, 0);
    check_eq("dout_held", dout0 ^ dout1, xoodoo_ref(sv, NR));

    // Asynchronous reset mid-run, at round 5.
    sv = rand384(); m = rand384();
    din0 = sv ^ m; din1 = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10 + REF) begin
      rs = rand384();
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ready", ready, 1);
    check_eq("arst_done", done, 0);
    check_eq("arst_dout0", dout0, '0);
    check_eq("arst_dout1", dout1, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    sv = rand384(); m = rand384();
    run_op(sv ^ m, m, 0, 1'b0, lat);
    check_eq("lat_after_arst", lat, 2*NR + REF);
    check_eq("xor_after_arst", dout0 ^ dout1, xoodoo_ref(sv, NR));

    // Six-round instance.
    begin
      int k;
      sv = rand384(); m = rand384();
      check_eq("ready6_at_start", ready6, 1);
      din0 = sv ^ m; din1 = m; start6 = 1'b1;
      @(posedge clk); #1;
      start6 = 1'b0;
      k = 0;
      while (!done6 && k < 100) begin
        rs = rand384();
        @(posedge clk); #1;
        k++;
      end
      check_eq("lat_r6", k, 12 + REF);
      check_eq("xor_r6", dout0_6 ^ dout1_6, xoodoo_ref(sv, 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
